// File: rtl/fp_convert_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | fp_convert_scheduler: round-robin shared int<->float converter, 2 stages  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module convert_int_into_float (
  input  logic [24:0] int_i,
  output logic [31:0] float_o
);
  logic        w_sign;
  logic [24:0] w_mag;
  logic [4:0]  w_pos;
  logic [22:0] w_mant;
  logic [7:0]  w_exp;

  assign w_sign = int_i[24];
  assign w_mag  = w_sign ? (~int_i + 25'd1) : int_i;

  always_comb begin
    w_pos = '0;
    for (int i = 0; i < 25; i++) begin
      if (w_mag[i]) w_pos = 5'(i);
    end
  end

  // Magnitudes never exceed 2^24, so normalisation is exact and needs no rounding.
  assign w_mant  = 23'((w_mag << (5'd24 - w_pos)) >> 1);
  assign w_exp   = 8'd127 + {3'b000, w_pos};
  assign float_o = (w_mag == '0) ? 32'h0 : {w_sign, w_exp, w_mant};
endmodule

module convert_float_into_int (
  input  logic [31:0] float_i,
  output logic [24:0] int_o,
  output logic        ovf_o
);
  logic        w_sign;
  logic [7:0]  w_exp;
  logic [25:0] w_sig;
  logic [25:0] w_shr;
  logic [24:0] w_mag;

  assign w_sign = float_i[31];
  assign w_exp  = float_i[30:23];
  assign w_sig  = {2'b00, 1'b1, float_i[22:0]};
  // Right-shift keeps one guard bit; adding one then halving rounds half away from zero.
  assign w_shr  = {1'b0, 1'b1, float_i[22:0], 1'b0} >> (8'd150 - w_exp);

  always_comb begin
    if (w_exp >= 8'd150) begin
      w_mag = 25'(w_sig << (w_exp - 8'd150));
    end else begin
      w_mag = 25'((w_shr + 26'd1) >> 1);
    end
  end

  assign int_o = w_sign ? (~w_mag + 25'd1) : w_mag;
  assign ovf_o = (w_exp > 8'h97);
endmodule

module fp_convert_scheduler #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic             req0_op_i,
  input  logic [31:0]      req0_data_i,
  input  logic [3:0]       req0_tag_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic             req1_op_i,
  input  logic [31:0]      req1_data_i,
  input  logic [3:0]       req1_tag_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_data_o,
  output logic             rsp_id_o,
  output logic [3:0]       rsp_tag_o,
  output logic             rsp_ovf_o,
  output logic [CNT_W-1:0] grant_cnt0_o,
  output logic [CNT_W-1:0] grant_cnt1_o
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_op_q, s1_op_d;
  logic [31:0]      s1_data_q, s1_data_d;
  logic [3:0]       s1_tag_q, s1_tag_d;
  logic             s1_id_q, s1_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             rsp_id_q, rsp_id_d;
  logic [3:0]       rsp_tag_q, rsp_tag_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic        w_s2_free;
  logic        w_s1_free;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_acc0;
  logic        w_acc1;
  logic [31:0] w_i2f;
  logic [24:0] w_f2i;
  logic        w_f2i_ovf;
  logic [31:0] w_conv_data;
  logic        w_conv_ovf;

  convert_int_into_float u_i2f (
    .int_i   (s1_data_q[24:0]),
    .float_o (w_i2f)
  );

  convert_float_into_int u_f2i (
    .float_i (s1_data_q),
    .int_o   (w_f2i),
    .ovf_o   (w_f2i_ovf)
  );

  assign w_conv_data = s1_op_q ? {{7{w_f2i[24]}}, w_f2i} : w_i2f;
  assign w_conv_ovf  = s1_op_q & w_f2i_ovf;

  assign w_s2_free = !rsp_valid_q || rsp_ready_i;
  assign w_s1_free = !s1_valid_q || w_s2_free;

  // last_q == 1 means requester 1 was served last, so requester 0 wins a tie.
  assign w_gnt0 = req0_valid_i && (!req1_valid_i || last_q);
  assign w_gnt1 = req1_valid_i && (!req0_valid_i || !last_q);

  assign req0_ready_o = w_gnt0 && w_s1_free && !rst;
  assign req1_ready_o = w_gnt1 && w_s1_free && !rst;
  assign w_acc0       = req0_valid_i && req0_ready_o;
  assign w_acc1       = req1_valid_i && req1_ready_o;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_data_d   = s1_data_q;
    s1_tag_d    = s1_tag_q;
    s1_id_d     = s1_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_ovf_d   = rsp_ovf_q;
    last_d      = last_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;

    if (w_acc0) begin
      s1_valid_d = 1'b1;
      s1_op_d    = req0_op_i;
      s1_data_d  = req0_data_i;
      s1_tag_d   = req0_tag_i;
      s1_id_d    = 1'b0;
      last_d     = 1'b0;
      cnt0_d     = (cnt0_q == CNT_MAX) ? cnt0_q : cnt0_q + CNT_W'(1);
    end else if (w_acc1) begin
      s1_valid_d = 1'b1;
      s1_op_d    = req1_op_i;
      s1_data_d  = req1_data_i;
      s1_tag_d   = req1_tag_i;
      s1_id_d    = 1'b1;
      last_d     = 1'b1;
      cnt1_d     = (cnt1_q == CNT_MAX) ? cnt1_q : cnt1_q + CNT_W'(1);
    end else if (w_s2_free) begin
      s1_valid_d = 1'b0;
    end

    if (s1_valid_q && w_s2_free) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = w_conv_data;
      rsp_id_d    = s1_id_q;
      rsp_tag_d   = s1_tag_q;
      rsp_ovf_d   = w_conv_ovf;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= 1'b0;
      s1_data_q   <= '0;
      s1_tag_q    <= '0;
      s1_id_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= 1'b0;
      rsp_tag_q   <= '0;
      rsp_ovf_q   <= 1'b0;
      last_q      <= 1'b1;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_data_q   <= s1_data_d;
      s1_tag_q    <= s1_tag_d;
      s1_id_q     <= s1_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_ovf_q   <= rsp_ovf_d;
      last_q      <= last_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_tag_o    = rsp_tag_q;
  assign rsp_ovf_o    = rsp_ovf_q;
  assign grant_cnt0_o = cnt0_q;
  assign grant_cnt1_o = cnt1_q;
endmodule

`default_nettype wire

// File: tb/tb_fp_convert_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fp_convert_scheduler: randomized scoreboard bench for the converter   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fp_convert_scheduler;
  localparam int CNT_W = 4;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [31:0] data;
    logic        id;
    logic [3:0]  tag;
    logic        ovf;
  } rsp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             rv [2];
  logic             rop [2];
  logic [31:0]      rdat [2];
  logic [3:0]       rtag [2];
  logic             rdy0, rdy1;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_ovf;
  logic [31:0]      rsp_data;
  logic [3:0]       rsp_tag;
  logic [CNT_W-1:0] gcnt0, gcnt1;

  rsp_t exp_q [$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cnt_m [2];
  bit   acc [2];
  bit   fired;
  logic fire_id;
  int   cyc = 0;

  always #5 clk = ~clk;

  fp_convert_scheduler #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid_i (rv[0]),
    .req0_ready_o (rdy0),
    .req0_op_i    (rop[0]),
    .req0_data_i  (rdat[0]),
    .req0_tag_i   (rtag[0]),
    .req1_valid_i (rv[1]),
    .req1_ready_o (rdy1),
    .req1_op_i    (rop[1]),
    .req1_data_i  (rdat[1]),
    .req1_tag_i   (rtag[1]),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .rsp_id_o     (rsp_id),
    .rsp_tag_o    (rsp_tag),
    .rsp_ovf_o    (rsp_ovf),
    .grant_cnt0_o (gcnt0),
    .grant_cnt1_o (gcnt1)
  );

  // Reference conversion computed with real arithmetic, independent of bit tricks.
  function automatic rsp_t ref_model(input logic id, input logic op,
                                     input logic [31:0] d, input logic [3:0] tag);
    rsp_t        r;
    int          iv;
    int          e;
    real         x;
    logic [63:0] b;
    longint      l;
    logic [24:0] v25;
    r.id  = id;
    r.tag = tag;
    r.ovf = 1'b0;
    r.data = 32'h0;
    if (!op) begin
      iv = $signed({{7{d[24]}}, d[24:0]});
      if (iv != 0) begin
        x = real'(iv);
        b = $realtobits(x);
        r.data = {b[63], 8'(int'(b[62:52]) - 1023 + 127), b[51:29]};
      end
    end else begin
      e = int'(d[30:23]);
      r.ovf = (e > 151);
      if (!r.ovf) begin
        x = (8388608.0 + real'(d[22:0])) * (2.0 ** (e - 150));
        l = longint'($floor(x + 0.5));
        if (d[31]) l = -l;
        v25 = l[24:0];
        r.data = {{7{v25[24]}}, v25};
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_data(input logic op);
    logic [31:0] m;
    int          e;
    m = $urandom;
    if (!op) begin
      case ($urandom_range(0, 7))
        0:       return 32'h0;
        1:       return 32'h01000000;
        2:       return 32'h00FFFFFF;
        default: return m;
      endcase
    end
    e = ($urandom_range(0, 7) == 0) ? $urandom_range(152, 255) : $urandom_range(100, 151);
    return {1'($urandom_range(0, 1)), 8'(e), m[22:0]};
  endfunction

  task automatic set_req(input int id, input logic op, input logic [31:0] d, input logic [3:0] tag);
    rv[id]   = 1'b1;
    rop[id]  = op;
    rdat[id] = d;
    rtag[id] = tag;
  endtask

  task automatic rand_req(input int id);
    logic op;
    op = 1'($urandom_range(0, 1));
    set_req(id, op, rand_data(op), 4'($urandom));
  endtask

  // One clock: sample handshakes before the edge, score responses, then advance.
  task automatic tick();
    rsp_t got, e;
    @(negedge clk);
    acc[0] = rv[0] && rdy0;
    acc[1] = rv[1] && rdy1;
    if (rv[0] && rv[1]) begin
      n_checks++;
      if (rdy0 && rdy1) $display("FAIL one_ready: ready0=1 ready1=1, required at most one high");
      else n_pass++;
    end
    fired = rsp_valid && rsp_ready;
    if (fired) begin
      got = {rsp_data, rsp_id, rsp_tag, rsp_ovf};
      fire_id = rsp_id;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard: unexpected response data=%h id=%0d tag=%0d, required none",
                 rsp_data, rsp_id, rsp_tag);
      end else begin
        e = exp_q.pop_front();
        if (got.id !== e.id || got.tag !== e.tag || got.ovf !== e.ovf ||
            (!e.ovf && got.data !== e.data))
          $display("FAIL scoreboard: got data=%h id=%0d tag=%0d ovf=%0d, required data=%h id=%0d tag=%0d ovf=%0d",
                   got.data, got.id, got.tag, got.ovf, e.data, e.id, e.tag, e.ovf);
        else n_pass++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        exp_q.push_back(ref_model(1'(i), rop[i], rdat[i], rtag[i]));
        if (cnt_m[i] < CNT_SAT) cnt_m[i]++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) if (acc[i]) rv[i] = 1'b0;
  endtask

  task automatic wait_acc();
    int g = 0;
    rsp_ready = 1'b1;
    while ((rv[0] || rv[1]) && g < 50) begin
      tick();
      g++;
    end
    if (rv[0] || rv[1]) begin
      n_checks++;
      $display("FAIL accept_timeout: pending=%0d%0d, required none pending", rv[0], rv[1]);
      rv[0] = 1'b0;
      rv[1] = 1'b0;
    end
  endtask

  task automatic drain();
    int g = 0;
    rsp_ready = 1'b1;
    while ((exp_q.size() != 0 || rsp_valid) && g < 20) begin
      tick();
      g++;
    end
    n_checks++;
    if (exp_q.size() != 0 || rsp_valid !== 1'b0)
      $display("FAIL drain: outstanding=%0d rsp_valid=%0d, required 0 and 0", exp_q.size(), rsp_valid);
    else n_pass++;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    rv[0] = 1'b0;
    rv[1] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    cnt_m[0] = 0;
    cnt_m[1] = 0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    rsp_ready = 1'b1;
    set_req(0, 1'b0, 32'h7, 4'h1);
    set_req(1, 1'b0, 32'h9, 4'h2);
    @(posedge clk);
    @(posedge clk);
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_id !== 1'b0 || rsp_tag !== 4'h0 ||
        rsp_ovf !== 1'b0 || gcnt0 !== '0 || gcnt1 !== '0)
      $display("FAIL reset_state: valid=%0d data=%h id=%0d tag=%0d ovf=%0d cnt=%0d/%0d, required all 0",
               rsp_valid, rsp_data, rsp_id, rsp_tag, rsp_ovf, gcnt0, gcnt1);
    else n_pass++;
    n_checks++;
    if (rdy0 !== 1'b0 || rdy1 !== 1'b0)
      $display("FAIL reset_ready: ready0=%0d ready1=%0d, required 0 0", rdy0, rdy1);
    else n_pass++;
    rst = 1'b0;
    exp_q.delete();
    cnt_m[0] = 0;
    cnt_m[1] = 0;
    #1;
    n_checks++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b0)
      $display("FAIL first_tie: ready0=%0d ready1=%0d, required 1 0", rdy0, rdy1);
    else n_pass++;
    wait_acc();
    drain();
  endtask

  task automatic test_i2f();
    logic [31:0] din [3];
    logic [31:0] dexp [3];
    din  = '{32'h00000003, 32'h01FFFFFF, 32'h00000000};
    dexp = '{32'h40400000, 32'hBF800000, 32'h00000000};
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_req(0, 1'b0, din[k], 4'h5);
      tick();
      n_checks++;
      if (!acc[0] || rsp_valid !== 1'b0)
        $display("FAIL i2f_latency%0d: accepted=%0d rsp_valid=%0d, required 1 0", k, acc[0], rsp_valid);
      else n_pass++;
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== dexp[k] || rsp_id !== 1'b0 || rsp_tag !== 4'h5 || rsp_ovf !== 1'b0)
        $display("FAIL i2f%0d: valid=%0d data=%h id=%0d tag=%0d ovf=%0d, required 1 %h 0 5 0",
                 k, rsp_valid, rsp_data, rsp_id, rsp_tag, rsp_ovf, dexp[k]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_f2i();
    logic [31:0] din [3];
    logic [31:0] dexp [3];
    logic        oexp [3];
    din  = '{32'h40200000, 32'hC0400000, 32'h4C000000};
    dexp = '{32'h00000003, 32'hFFFFFFFD, 32'h00000000};
    oexp = '{1'b0, 1'b0, 1'b1};
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_req(1, 1'b1, din[k], 4'(k + 8));
      tick();
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_tag !== 4'(k + 8) || rsp_ovf !== oexp[k] ||
          (!oexp[k] && rsp_data !== dexp[k]))
        $display("FAIL f2i%0d: valid=%0d data=%h id=%0d tag=%0d ovf=%0d, required 1 %h 1 %0d %0d",
                 k, rsp_valid, rsp_data, rsp_id, rsp_tag, rsp_ovf, dexp[k], k + 8, oexp[k]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_round_robin();
    int order [$];
    int acyc [$];
    int fids [$];
    int fcyc [$];
    int g = 0;
    do_reset();
    rsp_ready = 1'b1;
    rand_req(0);
    rand_req(1);
    while (fids.size() < 6 && g < 40) begin
      tick();
      g++;
      if (fired) begin
        fids.push_back(int'(fire_id));
        fcyc.push_back(cyc);
      end
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          order.push_back(i);
          acyc.push_back(cyc);
          if (order.size() < 5) rand_req(i);
        end
      end
    end
    n_checks++;
    if (order.size() != 6 || fids.size() != 6)
      $display("FAIL rr_count: accepts=%0d responses=%0d, required 6 6", order.size(), fids.size());
    else begin
      n_pass++;
      for (int k = 0; k < 6; k++) begin
        n_checks++;
        if (order[k] != k % 2 || fids[k] != k % 2 || (k > 0 && (acyc[k] != acyc[k-1] + 1 || fcyc[k] != fcyc[k-1] + 1)))
          $display("FAIL rr_order%0d: accept_id=%0d rsp_id=%0d, required %0d on consecutive cycles",
                   k, order[k], fids[k], k % 2);
        else n_pass++;
      end
    end
    drain();
    n_checks++;
    if (gcnt0 !== 4'd3 || gcnt1 !== 4'd3)
      $display("FAIL rr_counters: cnt0=%0d cnt1=%0d, required 3 3", gcnt0, gcnt1);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int          sent = 1;
    int          n_acc = 0;
    logic [38:0] snap;
    rsp_ready = 1'b0;
    rand_req(0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (acc[0]) begin
        n_acc++;
        if (sent < 3) begin
          rand_req(0);
          sent++;
        end
      end
      if (c == 2) snap = {rsp_valid, rsp_data, rsp_id, rsp_tag, rsp_ovf};
      if (c >= 2) begin
        n_checks++;
        if ({rsp_valid, rsp_data, rsp_id, rsp_tag, rsp_ovf} !== snap || snap[38] !== 1'b1 ||
            rdy0 !== 1'b0 || rdy1 !== 1'b0)
          $display("FAIL bp_hold%0d: rsp=%h ready=%0d%0d, required rsp=%h (valid) ready=00",
                   c, {rsp_valid, rsp_data, rsp_id, rsp_tag, rsp_ovf}, rdy0, rdy1, snap);
        else n_pass++;
      end
    end
    n_checks++;
    if (n_acc != 2) $display("FAIL bp_accepts: accepted=%0d, required 2", n_acc);
    else n_pass++;
    wait_acc();
    drain();
  endtask

  task automatic test_reset_midflight();
    rsp_ready = 1'b1;
    rand_req(0);
    tick();
    n_checks++;
    if (!acc[0]) $display("FAIL mid_accept: accepted=0, required 1");
    else n_pass++;
    rand_req(0);
    rand_req(1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    cnt_m[0] = 0;
    cnt_m[1] = 0;
    #1;
    n_checks++;
    if (acc[0] || acc[1] || rsp_valid !== 1'b0 || gcnt0 !== '0 || gcnt1 !== '0)
      $display("FAIL mid_reset: acc=%0d%0d rsp_valid=%0d cnt=%0d/%0d, required 00 0 0/0",
               acc[0], acc[1], rsp_valid, gcnt0, gcnt1);
    else n_pass++;
    n_checks++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b0)
      $display("FAIL mid_tie: ready0=%0d ready1=%0d, required 1 0", rdy0, rdy1);
    else n_pass++;
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL mid_no_rsp: rsp_valid=%0d, required 0", rsp_valid);
    else n_pass++;
    wait_acc();
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) if (!rv[i] && $urandom_range(0, 2) == 0) rand_req(i);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    wait_acc();
    drain();
    n_checks++;
    if (int'(gcnt0) != cnt_m[0] || int'(gcnt1) != cnt_m[1])
      $display("FAIL rand_counters: cnt=%0d/%0d, required %0d/%0d", gcnt0, gcnt1, cnt_m[0], cnt_m[1]);
    else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 17; k++) begin
      rand_req(0);
      wait_acc();
    end
    drain();
    n_checks++;
    if (gcnt0 !== 4'hF || gcnt1 !== 4'h0)
      $display("FAIL saturation: cnt0=%0d cnt1=%0d, required 15 0", gcnt0, gcnt1);
    else n_pass++;
  endtask

  initial begin
    rst       = 1'b1;
    rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rv[i]   = 1'b0;
      rop[i]  = 1'b0;
      rdat[i] = 32'h0;
      rtag[i] = 4'h0;
    end
    test_reset();
    test_i2f();
    test_f2i();
    test_round_robin();
    test_backpressure();
    test_reset_midflight();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
